// File: rtl/ir_pkg.sv
// Shared defaults and immediate-drive decode for the instruction prefetch queue.
package ir_pkg;
    localparam int IR_WIDTH    = 16;
    localparam int IR_DEPTH    = 4;
    localparam int IR_IMM_BITS = 8;

    typedef enum logic [1:0] {
        IMM_OFF  = 2'd0,
        IMM_ZERO = 2'd1,
        IMM_ONE  = 2'd2
    } imm_mode_e;

    // Both enables low is illegal and must leave the bus floating.
    function automatic imm_mode_e imm_mode(input logic enl_bar, input logic enh_bar);
        case ({enl_bar, enh_bar})
            2'b01:   return IMM_ZERO;
            2'b10:   return IMM_ONE;
            default: return IMM_OFF;
        endcase
    endfunction
endpackage

// File: rtl/ir_prefetch_if.sv
// Control strobes and status of the prefetch unit; the shared bus stays a plain inout.
interface ir_prefetch_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             push_bar;
    logic             next_bar;
    logic             flush_bar;
    logic             enl_bar;
    logic             enh_bar;
    logic [WIDTH-1:0] value;
    logic             valid;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             overflow;

    modport master (
        output push_bar, next_bar, flush_bar, enl_bar, enh_bar,
        input  value, valid, count, full, empty, overflow
    );

    modport slave (
        input  push_bar, next_bar, flush_bar, enl_bar, enh_bar,
        output value, valid, count, full, empty, overflow
    );
endinterface

// File: rtl/ir_queue.sv
// Circular FIFO of prefetched words; pointers wrap naturally, count tells full from empty.
module ir_queue #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             clk,
    input  logic             reset_bar,
    input  logic             wr,
    input  logic             rd,
    input  logic             clr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;
            case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is unreadable while count is zero, so it carries no reset.
    always_ff @(posedge clk) begin
        if (wr && !clr) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/ir_prefetch.sv
// Instruction prefetch: queue in front of the IR, empty-queue bypass, sticky overflow, immediate bus drive.
module ir_prefetch
    import ir_pkg::*;
#(
    parameter int WIDTH    = IR_WIDTH,
    parameter int DEPTH    = IR_DEPTH,
    parameter int IMM_BITS = IR_IMM_BITS,
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_bar,
    inout  wire  [WIDTH-1:0] bus,
    ir_prefetch_if.slave     irp
);
    logic             push;
    logic             next;
    logic             flush;
    logic             q_full;
    logic             q_empty;
    logic             q_wr;
    logic             q_rd;
    logic [WIDTH-1:0] head;
    logic [CW-1:0]    q_count;
    logic [WIDTH-1:0] ir_value;
    logic             ir_valid;
    logic             ovf;
    imm_mode_e        mode;
    logic [WIDTH-1:0] imm_word;

    assign push    = !irp.push_bar;
    assign next    = !irp.next_bar;
    assign flush   = !irp.flush_bar;
    assign q_full  = (q_count == CW'(DEPTH));
    assign q_empty = (q_count == '0);

    // A simultaneous next frees the head slot, so a full queue still accepts the word;
    // on an empty queue the word bypasses straight into the IR instead.
    assign q_wr = push && !flush && (!q_full || next) && !(next && q_empty);
    assign q_rd = next && !flush && !q_empty;

    ir_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .reset_bar (reset_bar),
        .wr        (q_wr),
        .rd        (q_rd),
        .clr       (flush),
        .wdata     (bus),
        .rdata     (head),
        .count     (q_count)
    );

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            ir_value <= '0;
            ir_valid <= 1'b0;
            ovf      <= 1'b0;
        end else if (flush) begin
            ir_valid <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (push && !next && q_full) ovf <= 1'b1;
            if (next) begin
                if (!q_empty) begin
                    ir_value <= head;
                    ir_valid <= 1'b1;
                end else if (push) begin
                    ir_value <= bus;
                    ir_valid <= 1'b1;
                end else begin
                    ir_valid <= 1'b0;
                end
            end
        end
    end

    assign mode     = imm_mode(irp.enl_bar, irp.enh_bar);
    assign imm_word = {{(WIDTH-IMM_BITS){mode == IMM_ONE}}, ir_value[IMM_BITS-1:0]};
    assign bus      = (mode != IMM_OFF) ? imm_word : {WIDTH{1'bz}};

    assign irp.value    = ir_value;
    assign irp.valid    = ir_valid;
    assign irp.count    = q_count;
    assign irp.full     = q_full;
    assign irp.empty    = q_empty;
    assign irp.overflow = ovf;
endmodule
